obb_update_scheduler: RTL and testbench

- Per-frame sequencer for the combinational obb_updater and the OBB state RAM.
- Each frame has two phases:
  - Impulse phase: drains impulses from the contact solver, one read-modify-write per impulse, with impulse_en=1 and update_en=0.
  - Integrate phase: sweeps every body with update_en=1 and impulse_en=0, pipelined at one body per cycle.
- Sits between the contact solver, the state RAM and a single shared obb_updater instance in the physics top.

---
 rtl/obb_pkg.sv | 42 ++++
 rtl/obb_update_scheduler.sv | 148 ++++++++++++++
 tb/tb_obb_update_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obb_pkg.sv
// +----------------------------------------------------------------------+
// | obb_pkg: shared OBB state, impulse and scheduler types               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package obb_pkg;

    typedef struct packed {
        logic signed [31:0] pos_x;
        logic signed [31:0] pos_y;
        logic signed [31:0] vel_x;
        logic signed [31:0] vel_y;
        logic signed [15:0] ang;
        logic signed [15:0] omega;
    } obb_t;

    localparam int OBB_W     = $bits(obb_t);
    localparam int IMP_W     = 64;
    localparam int ROT_W     = 11;
    // Widest body index the latched impulse can hold; IDX_W must not exceed it.
    localparam int IDX_MAX_W = 8;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic [IMP_W-1:0]     vec;
        logic [ROT_W-1:0]     rot;
    } impulse_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        IMP_WAIT  = 3'd1,
        IMP_READ  = 3'd2,
        IMP_APPLY = 3'd3,
        INT_RUN   = 3'd4,
        INT_LAST  = 3'd5,
        DONE      = 3'd6
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/obb_update_scheduler.sv
// +----------------------------------------------------------------------+
// | obb_update_scheduler: per-frame impulse/integrate sequencer for the  |
// | shared obb_updater and OBB state RAM.                Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module obb_update_scheduler #(
    parameter int NUM_OBB = 8,
    parameter int IDX_W   = 3,
    parameter int OBB_W   = obb_pkg::OBB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             solver_done,
    input  logic             imp_valid,
    output logic             imp_ready,
    input  logic [IDX_W-1:0] imp_idx,
    input  logic [63:0]      imp_vec,
    input  logic [10:0]      imp_rot,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [OBB_W-1:0] rd_data,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_addr,
    output logic [OBB_W-1:0] wr_data,
    output logic             upd_impulse_en,
    output logic             upd_update_en,
    output logic [63:0]      upd_impulse,
    output logic [10:0]      upd_rot,
    output logic [OBB_W-1:0] upd_prev,
    input  logic [OBB_W-1:0] upd_next,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_overrun
);
    import obb_pkg::*;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_OBB - 1);

    sched_state_e     r_state, w_state_nxt;
    logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
    impulse_t         r_imp, w_imp_nxt;
    logic             w_imp_in_range;
    logic [IDX_W-1:0] w_imp_addr;

    assign upd_prev       = rd_data;
    assign wr_data        = upd_next;
    assign busy           = (r_state != IDLE);
    assign frame_overrun  = frame_tick && busy;
    assign w_imp_addr     = r_imp.idx[IDX_W-1:0];
    // Out-of-range entries still take their slot but never touch the RAM.
    assign w_imp_in_range = (32'(r_imp.idx) < NUM_OBB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_imp   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_imp   <= w_imp_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_imp_nxt      = r_imp;
        imp_ready      = 1'b0;
        rd_en          = 1'b0;
        rd_addr        = '0;
        wr_en          = 1'b0;
        wr_addr        = '0;
        upd_impulse_en = 1'b0;
        upd_update_en  = 1'b0;
        upd_impulse    = '0;
        upd_rot        = '0;
        frame_done     = 1'b0;

        case (r_state)
            IDLE: begin
                if (frame_tick) begin
                    w_state_nxt = IMP_WAIT;
                end
            end
            IMP_WAIT: begin
                imp_ready = imp_valid;
                if (imp_valid) begin
                    w_imp_nxt.idx = IDX_MAX_W'(imp_idx);
                    w_imp_nxt.vec = imp_vec;
                    w_imp_nxt.rot = imp_rot;
                    w_state_nxt   = IMP_READ;
                end else if (solver_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = INT_RUN;
                end
            end
            IMP_READ: begin
                rd_en       = w_imp_in_range;
                rd_addr     = w_imp_addr;
                upd_impulse = r_imp.vec;
                upd_rot     = r_imp.rot;
                w_state_nxt = IMP_APPLY;
            end
            IMP_APPLY: begin
                upd_impulse_en = 1'b1;
                upd_impulse    = r_imp.vec;
                upd_rot        = r_imp.rot;
                wr_en          = w_imp_in_range;
                wr_addr        = w_imp_addr;
                w_state_nxt    = IMP_WAIT;
            end
            INT_RUN: begin
                // Read body k while writing back body k-1 read last cycle.
                rd_en   = 1'b1;
                rd_addr = r_cnt;
                if (r_cnt != '0) begin
                    wr_en         = 1'b1;
                    wr_addr       = r_cnt - 1'b1;
                    upd_update_en = 1'b1;
                end
                if (r_cnt == c_last_idx) begin
                    w_state_nxt = INT_LAST;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            INT_LAST: begin
                wr_en         = 1'b1;
                wr_addr       = c_last_idx;
                upd_update_en = 1'b1;
                w_state_nxt   = DONE;
            end
            DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_obb_update_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_obb_update_scheduler: directed self-checking bench with RAM model |
// | and stub updater.                                    Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_obb_update_scheduler;
    import obb_pkg::*;

    localparam int NUM_OBB = 4;
    localparam int IDX_W   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             frame_tick, solver_done, imp_valid, imp_ready;
    logic [IDX_W-1:0] imp_idx;
    logic [63:0]      imp_vec;
    logic [10:0]      imp_rot;
    logic             rd_en, wr_en;
    logic [IDX_W-1:0] rd_addr, wr_addr;
    logic [OBB_W-1:0] rd_data, wr_data, upd_prev, upd_next;
    logic             upd_impulse_en, upd_update_en;
    logic [63:0]      upd_impulse;
    logic [10:0]      upd_rot;
    logic             busy, frame_done, frame_overrun;

    int n_checks = 0;
    int n_errors = 0;

    obb_t ram [NUM_OBB];
    logic ram_load;
    int   exp_px  [NUM_OBB];
    int   exp_ang [NUM_OBB];
    obb_t stub_prev, stub_next;

    always #5 clk = ~clk;

    obb_update_scheduler #(.NUM_OBB(NUM_OBB), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .solver_done(solver_done),
        .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_idx(imp_idx),
        .imp_vec(imp_vec), .imp_rot(imp_rot), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .upd_impulse_en(upd_impulse_en), .upd_update_en(upd_update_en),
        .upd_impulse(upd_impulse), .upd_rot(upd_rot), .upd_prev(upd_prev),
        .upd_next(upd_next), .busy(busy), .frame_done(frame_done),
        .frame_overrun(frame_overrun)
    );

    function automatic obb_t init_obb(input int i);
        obb_t o;
        o       = '0;
        o.pos_x = 32'(100 * i);
        o.pos_y = 32'(i + 1);
        o.ang   = 16'(10 * i);
        return o;
    endfunction

    // Stub updater: impulse adds vec.x to pos_x, integrate bumps ang by one.
    assign stub_prev = upd_prev;
    always_comb begin
        stub_next = stub_prev;
        if (upd_impulse_en) stub_next.pos_x = stub_prev.pos_x + upd_impulse[63:32];
        if (upd_update_en)  stub_next.ang   = stub_prev.ang + 16'sd1;
    end
    assign upd_next = stub_next;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < NUM_OBB; i++) ram[i] <= init_obb(i);
        end else if (wr_en) begin
            ram[wr_addr[1:0]] <= wr_data;
        end
        if (rd_en) rd_data <= ram[rd_addr[1:0]];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < NUM_OBB; i++) begin
            check_eq($sformatf("%s_px%0d", tag, i), 64'(ram[i].pos_x), 64'(exp_px[i]));
            check_eq($sformatf("%s_ang%0d", tag, i), 64'(ram[i].ang), 64'(exp_ang[i]));
        end
    endtask

    task automatic bump_ang();
        for (int i = 0; i < NUM_OBB; i++) exp_ang[i] = exp_ang[i] + 1;
    endtask

    task automatic start_frame(input bit sd);
        @(negedge clk);
        frame_tick  = 1'b1;
        solver_done = sd;
        @(negedge clk);
        frame_tick  = 1'b0;
    endtask

    // Impulse-free frame, cycle-accurate; ovr>0 injects frame_tick at that cycle.
    task automatic run_sweep(input string tag, input int ovr);
        bit er, ew;
        @(negedge clk);
        frame_tick  = 1'b1;
        solver_done = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            frame_tick = (c == ovr);
            #1;
            er = (c >= 2 && c <= 5);
            ew = (c >= 3 && c <= 6);
            check_eq($sformatf("%s_busy_c%0d", tag, c), busy, (c <= 7));
            check_eq($sformatf("%s_rden_c%0d", tag, c), rd_en, er);
            if (er) check_eq($sformatf("%s_rdaddr_c%0d", tag, c), rd_addr, c - 2);
            check_eq($sformatf("%s_wren_c%0d", tag, c), wr_en, ew);
            if (ew) check_eq($sformatf("%s_wraddr_c%0d", tag, c), wr_addr, c - 3);
            check_eq($sformatf("%s_upden_c%0d", tag, c), upd_update_en, ew);
            check_eq($sformatf("%s_impen_c%0d", tag, c), upd_impulse_en, 0);
            check_eq($sformatf("%s_done_c%0d", tag, c), frame_done, (c == 7));
            check_eq($sformatf("%s_ovr_c%0d", tag, c), frame_overrun, (c == ovr));
        end
        frame_tick = 1'b0;
    endtask

    task automatic push_imp(input logic [IDX_W-1:0] idx, input logic signed [31:0] x,
                            input bit in_rng, output int waited);
        logic [63:0] vec;
        vec       = {x, 32'h0000_0007};
        imp_idx   = idx;
        imp_vec   = vec;
        imp_rot   = 11'h015;
        imp_valid = 1'b1;
        waited    = 0;
        #1;
        while (!imp_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check_eq("imp_ready", imp_ready, 1);
        @(negedge clk);
        imp_valid = 1'b0;
        #1;
        check_eq("read_rden", rd_en, in_rng);
        if (in_rng) check_eq("read_addr", rd_addr, idx);
        check_eq("read_wren", wr_en, 0);
        check_eq("read_impen", upd_impulse_en, 0);
        @(negedge clk);
        #1;
        check_eq("apply_wren", wr_en, in_rng);
        if (in_rng) check_eq("apply_addr", wr_addr, idx);
        check_eq("apply_rden", rd_en, 0);
        check_eq("apply_impen", upd_impulse_en, 1);
        check_eq("apply_upden", upd_update_en, 0);
        check_eq("apply_vec", upd_impulse, vec);
        check_eq("apply_rot", upd_rot, 11'h015);
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (frame_done) dones++;
            if (!busy) break;
        end
        check_eq({tag, "_idle"}, busy, 0);
        check_eq({tag, "_ndone"}, dones, 1);
    endtask

    initial begin
        int w;
        rst_n       = 1'b0;
        ram_load    = 1'b1;
        frame_tick  = 1'b0;
        solver_done = 1'b0;
        imp_valid   = 1'b1;
        imp_idx     = '0;
        imp_vec     = '0;
        imp_rot     = '0;
        for (int i = 0; i < NUM_OBB; i++) begin
            exp_px[i]  = 100 * i;
            exp_ang[i] = 10 * i;
        end
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", imp_ready, 0);
        check_eq("rst_rden", rd_en, 0);
        check_eq("rst_wren", wr_en, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_impulse", upd_impulse, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        ram_load  = 1'b0;
        imp_valid = 1'b0;
        check_ram("init");

        // Impulse-free frame timing, then the same with an overrun tick in INT_RUN.
        run_sweep("sweep", 0);
        bump_ang();
        check_ram("sweep");
        run_sweep("ovr", 3);
        bump_ang();
        check_ram("ovr");

        // Two back-to-back impulses to body 2 must accumulate.
        start_frame(1'b0);
        push_imp(3'd2, 32'sd5, 1'b1, w);
        check_eq("imp1_wait", w, 0);
        push_imp(3'd2, 32'sd9, 1'b1, w);
        check_eq("imp2_b2b_wait", w, 0);
        solver_done = 1'b1;
        wait_done("imp");
        exp_px[2] = exp_px[2] + 14;
        bump_ang();
        check_ram("imp");

        // Out-of-range body index: accepted, no RAM traffic.
        start_frame(1'b0);
        push_imp(3'd5, 32'sd7, 1'b0, w);
        solver_done = 1'b1;
        wait_done("oor");
        bump_ang();
        check_ram("oor");

        // Solver stall holds IMP_WAIT until solver_done rises.
        start_frame(1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq($sformatf("stall_busy%0d", i), busy, 1);
            check_eq($sformatf("stall_rden%0d", i), rd_en, 0);
            @(negedge clk);
        end
        solver_done = 1'b1;
        @(negedge clk);
        #1;
        check_eq("stall_run_rden", rd_en, 1);
        check_eq("stall_run_addr", rd_addr, 0);
        wait_done("stall");
        bump_ang();
        check_ram("stall");

        // Asynchronous reset during IMP_APPLY aborts without a write.
        start_frame(1'b0);
        imp_idx   = 3'd1;
        imp_vec   = {32'sd50, 32'd0};
        imp_rot   = 11'd1;
        imp_valid = 1'b1;
        @(negedge clk);
        imp_valid = 1'b0;
        @(negedge clk);
        #1;
        check_eq("abort_pre_wren", wr_en, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_wren", wr_en, 0);
        check_eq("abort_impen", upd_impulse_en, 0);
        check_eq("abort_impulse", upd_impulse, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_ram("abort");
        run_sweep("after", 0);
        bump_ang();
        check_ram("after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
